// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: op codes, FSM states and big-endian lane helpers for mips_mem_unit
package mips_mem_pkg;
  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_SW = 2'b01,
    OP_SB = 2'b10,
    OP_LB = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } state_e;
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;
  // Bit offset of a byte lane; lane 0 is the most significant byte.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return lane == LANE_0 ? 5'd24 :
           lane == LANE_1 ? 5'd16 :
           lane == LANE_2 ? 5'd8  :
           lane == LANE_3 ? 5'd0  : 5'd0;
  endfunction
endpackage

// File: rtl/mips_mem_unit_byte_lane_unit.sv
// byte_lane_unit: big-endian byte extract (sign-extended) and byte merge
// ext_word/lane -> ext_sext : selected byte of ext_word, sign-extended to 32 bits
// mrg_word/mrg_byte/lane -> mrg_out : mrg_word with byte lane replaced by mrg_byte
module byte_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [31:0] ext_word,
  input  logic [1:0]  lane,
  output logic [31:0] ext_sext,
  input  logic [31:0] mrg_word,
  input  logic [7:0]  mrg_byte,
  output logic [31:0] mrg_out
);
  logic [4:0] sh;
  logic [7:0] sel;
  always_comb begin
    sh       = lane_shift(lane);
    sel      = 8'(ext_word >> sh);
    ext_sext = {{24{sel[7]}}, sel};
    mrg_out  = (mrg_word & ~(32'h0000_00FF << sh)) | (32'(mrg_byte) << sh);
  end
endmodule

// File: rtl/mips_mem_unit.sv
// mips_mem_unit: single-request word/byte memory with wait states and byte-store read-modify-write
module mips_mem_unit
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  logic [31:0] mem [DEPTH];
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0] lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
  logic err_q, err_d, rv_q, rv_d, rerr_q, rerr_d;
  logic [2:0] cnt_q, cnt_d;
  logic mem_we;
  logic [31:0] mem_wdata, rd_word, lb_word, sb_word;
  logic bad_req;
  assign rd_word = mem[idx_q];
  byte_lane_unit u_lane (
    .ext_word (rd_word),
    .lane     (lane_q),
    .ext_sext (lb_word),
    .mrg_word (buf_q),
    .mrg_byte (wdata_q[7:0]),
    .mrg_out  (sb_word)
  );
  assign bad_req = ((req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] != 2'b00)
                   || req_addr[31:2] >= 30'(DEPTH);
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = 3'd0;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        op_d    = op_e'(req_op);
        idx_d   = req_addr[ADDR_W+1:2];
        lane_d  = req_addr[1:0];
        wdata_d = req_wdata;
        err_d   = bad_req;
        state_d = bad_req ? ST_RESP : (WAIT_STATES > 0 ? ST_WAIT : ST_ACCESS);
      end
      ST_WAIT: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_d == 3'(WAIT_STATES) ? ST_ACCESS : ST_WAIT;
      end
      ST_ACCESS: begin
        rdata_d = op_q == OP_LW ? rd_word : op_q == OP_LB ? lb_word : rdata_q;
        buf_d   = rd_word;
        mem_we  = op_q == OP_SW;
        state_d = op_q == OP_SB ? ST_MERGE : ST_RESP;
      end
      ST_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = sb_word;
        state_d   = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    rv_d   = state_d == ST_RESP;
    rerr_d = rv_d & err_d;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LW;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      rerr_q  <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      rerr_q  <= rerr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= mem_wdata;
  end
  assign req_ready  = state_q == ST_IDLE;
  assign busy       = state_q != ST_IDLE;
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
endmodule

// File: tb/tb_mips_mem_unit.sv
// tb_mips_mem_unit: scoreboard bench for mips_mem_unit with WAIT_STATES=1 and WAIT_STATES=0 instances
module tb_mips_mem_unit;
  import mips_mem_pkg::*;
  typedef struct {
    int          g;
    logic [31:0] rd;
    logic        err;
    int          lat;
    string       nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        v    [2];
  logic        rdy  [2];
  logic [1:0]  op   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        rv   [2];
  logic [31:0] rd   [2];
  logic        er   [2];
  logic        bsy  [2];
  exp_t sb[$];
  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc [2];
  logic prev_rv [2];
  bit hold_run = 1'b0;
  int last_acc0 = -1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mips_mem_unit #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(0), .INIT_FILE("")) u0 (
    .clock(clk), .reset(rst), .req_valid(v[0]), .req_ready(rdy[0]), .req_op(op[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]),
    .resp_err(er[0]), .busy(bsy[0])
  );
  mips_mem_unit #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(1), .INIT_FILE("")) u1 (
    .clock(clk), .reset(rst), .req_valid(v[1]), .req_ready(rdy[1]), .req_op(op[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]),
    .resp_err(er[1]), .busy(bsy[1])
  );
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rv[g]) begin
        exp_t e;
        int lat;
        cmp++;
        if (prev_rv[g]) begin
          bad++;
          $display("FAIL resp_pulse dut%0d: resp_valid high two cycles in a row", g);
        end else if (sb.size() == 0 || sb[0].g != g) begin
          bad++;
          $display("FAIL unexpected_resp dut%0d: resp_valid=1 rdata=%h err=%b, no response expected", g, rd[g], er[g]);
        end else begin
          e = sb.pop_front();
          lat = cyc - acc_cyc[g] + 1;
          if (rd[g] !== e.rd || er[g] !== e.err || lat != e.lat) begin
            bad++;
            $display("FAIL %s: got rdata=%h err=%b lat=%0d, need rdata=%h err=%b lat=%0d",
                     e.nm, rd[g], er[g], lat, e.rd, e.err, e.lat);
          end
        end
      end
      prev_rv[g] = rv[g];
      if (v[g] && rdy[g]) acc_cyc[g] = cyc + 1;
    end
    if (hold_run && v[0]) begin
      cmp++;
      if (bsy[0] !== !(v[0] && rdy[0])) begin
        bad++;
        $display("FAIL hold_busy: got busy=%b ready=%b, need busy low only in accept cycles", bsy[0], rdy[0]);
      end
      if (rdy[0]) begin
        if (last_acc0 >= 0) begin
          cmp++;
          if (cyc + 1 - last_acc0 != 3) begin
            bad++;
            $display("FAIL hold_spacing: got %0d cycles between accepts, need 3", cyc + 1 - last_acc0);
          end
        end
        last_acc0 = cyc + 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h need %h", nm, a, e);
    end
  endtask
  task automatic issue(input int g, input logic [1:0] o, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] erd, input bit eerr, input int lat, input bit push,
                       input bit hold, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) begin
      cmp++;
      bad++;
      $display("FAIL %s_ready_timeout: got req_ready=0 for 50 cycles, need 1", nm);
      return;
    end
    if (push) sb.push_back('{g, erd, eerr, lat, nm});
    v[g] = 1'b1;
    op[g] = o;
    addr[g] = a;
    wd[g] = w;
    @(posedge clk);
    #1;
    if (!hold) v[g] = 1'b0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      cmp++;
      bad++;
      $display("FAIL %s_drain: got %0d responses outstanding, need 0", nm, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, need completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int g = 0; g < 2; g++) begin
      v[g] = 1'b0; op[g] = 2'b00; addr[g] = 32'd0; wd[g] = 32'd0;
      acc_cyc[g] = 0; prev_rv[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy[1]), 32'd1);
    chk("rst_resp_valid", 32'(rv[1]), 32'd0);
    chk("rst_rdata", rd[1], 32'd0);
    chk("rst_err", 32'(er[1]), 32'd0);
    chk("rst_busy", 32'(bsy[1]), 32'd0);
    issue(1, OP_SW, 32'h40, 32'hDEADBEEF, 32'h0,        0, 3, 1, 0, "sw_40");
    issue(1, OP_LW, 32'h40, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, "lw_40");
    issue(1, OP_SW, 32'h10, 32'h11223344, 32'hDEADBEEF, 0, 3, 1, 0, "sw_10");
    issue(1, OP_SB, 32'h12, 32'h000000AA, 32'hDEADBEEF, 0, 4, 1, 0, "sb_12");
    issue(1, OP_LW, 32'h10, 32'h0,        32'h1122AA44, 0, 3, 1, 0, "lw_10_merged");
    issue(1, OP_SW, 32'h20, 32'h00F08000, 32'h1122AA44, 0, 3, 1, 0, "sw_20");
    issue(1, OP_LB, 32'h21, 32'h0,        32'hFFFFFFF0, 0, 3, 1, 0, "lb_21");
    issue(1, OP_LB, 32'h23, 32'h0,        32'h00000000, 0, 3, 1, 0, "lb_23");
    issue(1, OP_LB, 32'h22, 32'h0,        32'hFFFFFF80, 0, 3, 1, 0, "lb_22");
    issue(1, OP_SW, 32'h0,  32'hCAFEF00D, 32'hFFFFFF80, 0, 3, 1, 0, "sw_0");
    issue(1, OP_LW, 32'h42, 32'h0,        32'hFFFFFF80, 1, 1, 1, 0, "err_lw_misaligned");
    issue(1, OP_SW, 32'h1000, 32'h12345678, 32'hFFFFFF80, 1, 1, 1, 0, "err_sw_range");
    issue(1, OP_SW, 32'h42, 32'h0,        32'hFFFFFF80, 1, 1, 1, 0, "err_sw_misaligned");
    issue(1, OP_LW, 32'h0,  32'h0,        32'hCAFEF00D, 0, 3, 1, 0, "lw_0_untouched");
    issue(1, OP_LW, 32'h40, 32'h0,        32'hDEADBEEF, 0, 3, 1, 0, "lw_40_untouched");
    issue(1, OP_SB, 32'h40, 32'h00000055, 32'hDEADBEEF, 0, 4, 1, 0, "sb_40_lane0");
    issue(1, OP_LW, 32'h40, 32'h0,        32'h55ADBEEF, 0, 3, 1, 0, "lw_40_lane0");
    issue(1, OP_SW, 32'h80, 32'h00000005, 32'h55ADBEEF, 0, 3, 1, 0, "sw_80");
    drain("basic");
    issue(1, OP_SW, 32'h80, 32'h00000099, 32'h0, 0, 0, 0, 0, "sw_80_aborted");
    chk("abort_in_wait_busy", 32'(bsy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_ready", 32'(rdy[1]), 32'd1);
    chk("abort_busy", 32'(bsy[1]), 32'd0);
    issue(1, OP_LW, 32'h80, 32'h0, 32'h00000005, 0, 3, 1, 0, "lw_80_after_abort");
    drain("abort");
    hold_run = 1'b1;
    last_acc0 = -1;
    issue(0, OP_SW, 32'h0, 32'h1, 32'h0, 0, 2, 1, 1, "h_sw_0");
    issue(0, OP_SW, 32'h4, 32'h2, 32'h0, 0, 2, 1, 1, "h_sw_4");
    issue(0, OP_SW, 32'h8, 32'h3, 32'h0, 0, 2, 1, 1, "h_sw_8");
    issue(0, OP_LW, 32'h0, 32'h0, 32'h1, 0, 2, 1, 1, "h_lw_0");
    issue(0, OP_LW, 32'h4, 32'h0, 32'h2, 0, 2, 1, 1, "h_lw_4");
    issue(0, OP_LW, 32'h8, 32'h0, 32'h3, 0, 2, 1, 0, "h_lw_8");
    drain("hold");
    hold_run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
